// File: rtl/divekick_pkg.sv
// Shared types and constants for the dive/kick game: phase and winner encodings,
// player state codes and default frame timings.
package divekick_pkg;

  typedef enum logic [2:0] {
    TITLE      = 3'd0,
    READY      = 3'd1,
    FIGHT      = 3'd2,
    HIT_FREEZE = 3'd3,
    MATCH_OVER = 3'd4
  } game_phase_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2,
    WIN_DRAW = 2'd3
  } winner_t;

  // Player motion state codes that mean "kick active".
  localparam logic [2:0] PSTATE_KICK_A = 3'd2;
  localparam logic [2:0] PSTATE_KICK_B = 3'd5;

  localparam int DEF_WINS_TO_MATCH = 3;
  localparam int DEF_FREEZE_FRAMES = 60;
  localparam int DEF_READY_FRAMES  = 90;
  localparam int DEF_ROUND_FRAMES  = 5940;

endpackage

// File: rtl/frame_tick.sv
// Frame strobe synchronizer and rising-edge detector; tick_o is one clock wide,
// two clocks after the frame_clk edge. Also used by the render block.
module frame_tick (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic frame_clk_i,
  output logic tick_o
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= frame_clk_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign tick_o = sync2_q & ~prev_q;

endmodule

// File: rtl/round_controller.sv
// Match sequencer owning game phase: title, ready countdown, fight, hit freeze, match over.
// Optional round time limit is built when ROUND_TIMER_TIME_LIMIT_EN is defined.
module round_controller
  import divekick_pkg::*;
#(
  parameter int WINS_TO_MATCH = DEF_WINS_TO_MATCH,
  parameter int FREEZE_FRAMES = DEF_FREEZE_FRAMES,
  parameter int READY_FRAMES  = DEF_READY_FRAMES,
  parameter int ROUND_FRAMES  = DEF_ROUND_FRAMES
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       start,
  input  logic       p1_hit,
  input  logic       p2_hit,
  output logic       Freeze,
  output logic       round_reset,
  output logic [2:0] game_phase,
  output logic [2:0] p1_score,
  output logic [2:0] p2_score,
`ifdef ROUND_TIMER_TIME_LIMIT_EN
  output logic [6:0] round_time_left,
`endif
  output logic [1:0] winner
);

  localparam logic [2:0] WINS      = 3'(WINS_TO_MATCH);
  localparam logic [7:0] READY_END = 8'(READY_FRAMES - 1);
  localparam logic [7:0] FRZ_END   = 8'(FREEZE_FRAMES - 1);

  game_phase_t state_q, state_d;
  winner_t     winner_q, winner_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  p1_score_q, p1_score_d;
  logic [2:0]  p2_score_q, p2_score_d;
  logic        round_reset_q, round_reset_d;
  logic        start_q;
  logic        start_rise;
  logic        tick;
  logic        timeout;

  frame_tick u_frame_tick (
    .clk_i       (Clk),
    .rst_ni      (Reset_n),
    .frame_clk_i (frame_clk),
    .tick_o      (tick)
  );

  assign start_rise = start & ~start_q;

`ifdef ROUND_TIMER_TIME_LIMIT_EN
  localparam logic [12:0] ROUND_END = 13'(ROUND_FRAMES - 1);
  localparam logic [6:0]  SEC_INIT  = 7'(ROUND_FRAMES / 60);
  localparam logic [5:0]  SUB_INIT  = 6'(ROUND_FRAMES % 60);

  logic [12:0] rcnt_q, rcnt_d;
  logic [6:0]  sec_q, sec_d;
  logic [5:0]  sub_q, sub_d;

  assign timeout = tick && (rcnt_q == ROUND_END);

  // Seconds are tracked as (remaining / 60, remaining % 60) so no divider is needed.
  always_comb begin
    rcnt_d = rcnt_q;
    sec_d  = sec_q;
    sub_d  = sub_q;
    if (state_d == FIGHT && state_q != FIGHT) begin
      rcnt_d = '0;
      sec_d  = SEC_INIT;
      sub_d  = SUB_INIT;
    end else if (state_q == FIGHT && tick) begin
      rcnt_d = rcnt_q + 13'd1;
      if (sub_q == 6'd0) begin
        sub_d = 6'd59;
        if (sec_q != 7'd0) sec_d = sec_q - 7'd1;
      end else begin
        sub_d = sub_q - 6'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rcnt_q <= '0;
      sec_q  <= '0;
      sub_q  <= '0;
    end else begin
      rcnt_q <= rcnt_d;
      sec_q  <= sec_d;
      sub_q  <= sub_d;
    end
  end

  assign round_time_left = sec_q;
`else
  logic unused_round_frames;
  assign unused_round_frames = (ROUND_FRAMES != 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    winner_d      = winner_q;
    p1_score_d    = p1_score_q;
    p2_score_d    = p2_score_q;
    round_reset_d = 1'b0;
    cnt_d         = tick ? cnt_q + 8'd1 : cnt_q;

    case (state_q)
      TITLE: begin
        if (start_rise) begin
          state_d       = READY;
          round_reset_d = 1'b1;
          p1_score_d    = '0;
          p2_score_d    = '0;
          winner_d      = WIN_NONE;
        end
      end
      READY: begin
        if (tick && cnt_q == READY_END) state_d = FIGHT;
      end
      FIGHT: begin
        // Hits take priority over a timeout landing in the same clock.
        if (p1_hit && p2_hit) begin
          winner_d = WIN_DRAW;
          state_d  = HIT_FREEZE;
        end else if (p1_hit) begin
          if (p1_score_q != WINS) p1_score_d = p1_score_q + 3'd1;
          winner_d = WIN_P1;
          state_d  = HIT_FREEZE;
        end else if (p2_hit) begin
          if (p2_score_q != WINS) p2_score_d = p2_score_q + 3'd1;
          winner_d = WIN_P2;
          state_d  = HIT_FREEZE;
        end else if (timeout) begin
          winner_d = WIN_DRAW;
          state_d  = HIT_FREEZE;
        end
      end
      HIT_FREEZE: begin
        if (tick && cnt_q == FRZ_END) begin
          if (p1_score_q == WINS || p2_score_q == WINS) begin
            state_d = MATCH_OVER;
          end else begin
            state_d       = READY;
            round_reset_d = 1'b1;
            winner_d      = WIN_NONE;
          end
        end
      end
      MATCH_OVER: begin
        if (start_rise) begin
          state_d  = TITLE;
          winner_d = WIN_NONE;
        end
      end
      default: state_d = TITLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= TITLE;
      winner_q      <= WIN_NONE;
      cnt_q         <= '0;
      p1_score_q    <= '0;
      p2_score_q    <= '0;
      round_reset_q <= 1'b0;
      start_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      winner_q      <= winner_d;
      cnt_q         <= cnt_d;
      p1_score_q    <= p1_score_d;
      p2_score_q    <= p2_score_d;
      round_reset_q <= round_reset_d;
      start_q       <= start;
    end
  end

  assign Freeze      = (state_q != FIGHT);
  assign round_reset = round_reset_q;
  assign game_phase  = state_q;
  assign p1_score    = p1_score_q;
  assign p2_score    = p2_score_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller: reset, rounds, draws, match end, held start,
// and the round time limit when ROUND_TIMER_TIME_LIMIT_EN is defined.
module tb_round_controller;

  logic       Clk;
  logic       Reset_n;
  logic       frame_clk;
  logic       start;
  logic       p1_hit;
  logic       p2_hit;
  logic       Freeze;
  logic       round_reset;
  logic [2:0] game_phase;
  logic [2:0] p1_score;
  logic [2:0] p2_score;
  logic [1:0] winner;
`ifdef ROUND_TIMER_TIME_LIMIT_EN
  logic [6:0] round_time_left;
`endif

  int checks = 0;
  int errors = 0;
  int rr_cnt = 0;
  int rr_wide = 0;
  logic rr_prev = 1'b0;
  logic [2:0] exp_q[$];

  localparam logic [2:0] PH_TITLE = 3'd0, PH_READY = 3'd1, PH_FIGHT = 3'd2,
                         PH_FREEZE = 3'd3, PH_OVER = 3'd4;

  round_controller #(
    .WINS_TO_MATCH (3),
    .FREEZE_FRAMES (60),
    .READY_FRAMES  (90),
`ifdef ROUND_TIMER_TIME_LIMIT_EN
    .ROUND_FRAMES  (120)
`else
    .ROUND_FRAMES  (5940)
`endif
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_clk   (frame_clk),
    .start       (start),
    .p1_hit      (p1_hit),
    .p2_hit      (p2_hit),
    .Freeze      (Freeze),
    .round_reset (round_reset),
    .game_phase  (game_phase),
    .p1_score    (p1_score),
    .p2_score    (p2_score),
`ifdef ROUND_TIMER_TIME_LIMIT_EN
    .round_time_left (round_time_left),
`endif
    .winner      (winner)
  );

  // Clock and reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // round_reset pulse monitor: counts pulses and flags any pulse wider than one clock
  always @(negedge Clk) begin
    if (Reset_n && round_reset) rr_cnt++;
    if (Reset_n && round_reset && rr_prev) rr_wide++;
    rr_prev = round_reset;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic send_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk) frame_clk = 1'b1;
      repeat (3) @(negedge Clk);
      frame_clk = 1'b0;
      repeat (3) @(negedge Clk);
    end
  endtask

  task automatic press_start();
    @(negedge Clk) start = 1'b1;
    @(negedge Clk) start = 1'b0;
    @(negedge Clk);
  endtask

  task automatic pulse_hit(input logic h1, input logic h2);
    @(negedge Clk) begin
      p1_hit = h1;
      p2_hit = h2;
    end
    @(negedge Clk) begin
      p1_hit = 1'b0;
      p2_hit = 1'b0;
    end
  endtask

  initial begin
    int changes;
    logic [2:0] prev_ph;
    Reset_n = 1'b0;
    frame_clk = 1'b0;
    start = 1'b0;
    p1_hit = 1'b0;
    p2_hit = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_phase", 16'(game_phase), 16'(PH_TITLE));
    check("rst_freeze", 16'(Freeze), 16'd1);
    check("rst_rr", 16'(round_reset), 16'd0);
    check("rst_p1", 16'(p1_score), 16'd0);
    check("rst_winner", 16'(winner), 16'd0);
    @(negedge Clk) Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Round 1: P1 scores
    press_start();
    check("start_rr_cnt", 16'(rr_cnt), 16'd1);
    check("start_phase", 16'(game_phase), 16'(PH_READY));
    send_ticks(89);
    check("ready89_phase", 16'(game_phase), 16'(PH_READY));
    send_ticks(1);
    check("ready90_phase", 16'(game_phase), 16'(PH_FIGHT));
    check("fight_freeze", 16'(Freeze), 16'd0);
    pulse_hit(1'b1, 1'b0);
    check("p1hit_freeze", 16'(Freeze), 16'd1);
    check("p1hit_phase", 16'(game_phase), 16'(PH_FREEZE));
    check("p1hit_score", 16'(p1_score), 16'd1);
    check("p1hit_winner", 16'(winner), 16'd1);
    pulse_hit(1'b0, 1'b1);
    check("frz_ignore_p2", 16'(p2_score), 16'd0);
    send_ticks(59);
    check("frz59_phase", 16'(game_phase), 16'(PH_FREEZE));
    send_ticks(1);
    check("frz60_phase", 16'(game_phase), 16'(PH_READY));
    check("frz60_rr_cnt", 16'(rr_cnt), 16'd2);
    check("frz60_winner", 16'(winner), 16'd0);

    // Round 2: simultaneous hits draw
    send_ticks(90);
    pulse_hit(1'b1, 1'b1);
    check("draw_winner", 16'(winner), 16'd3);
    check("draw_p1", 16'(p1_score), 16'd1);
    check("draw_p2", 16'(p2_score), 16'd0);
    send_ticks(60);
    check("draw_back_phase", 16'(game_phase), 16'(PH_READY));
    check("draw_rr_cnt", 16'(rr_cnt), 16'd3);

    // Round 3: P1 to 2, then async reset mid-fight
    send_ticks(90);
    pulse_hit(1'b1, 1'b0);
    check("p1_two", 16'(p1_score), 16'd2);
    send_ticks(60);
    send_ticks(90);
    check("pre_rst_phase", 16'(game_phase), 16'(PH_FIGHT));
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    check("async_phase", 16'(game_phase), 16'(PH_TITLE));
    check("async_freeze", 16'(Freeze), 16'd1);
    check("async_p1", 16'(p1_score), 16'd0);
    @(negedge Clk) Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // P2 takes three straight rounds
    press_start();
    for (int r = 1; r <= 3; r++) exp_q.push_back(3'(r));
    for (int r = 1; r <= 3; r++) begin
      send_ticks(90);
      pulse_hit(1'b0, 1'b1);
      check("p2_score", 16'(p2_score), 16'(exp_q.pop_front()));
      check("p2_winner", 16'(winner), 16'd2);
      send_ticks(60);
      check("p2_round_end", 16'(game_phase), (r < 3) ? 16'(PH_READY) : 16'(PH_OVER));
    end
    check("over_winner", 16'(winner), 16'd2);
    check("over_p1", 16'(p1_score), 16'd0);
    pulse_hit(1'b1, 1'b1);
    pulse_hit(1'b0, 1'b1);
    check("over_ign_p1", 16'(p1_score), 16'd0);
    check("over_ign_p2", 16'(p2_score), 16'd3);
    send_ticks(2);
    check("over_hold", 16'(game_phase), 16'(PH_OVER));

    // Held start: exactly one transition to TITLE
    changes = 0;
    prev_ph = game_phase;
    @(negedge Clk) start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge Clk);
      if (game_phase != prev_ph) changes++;
      prev_ph = game_phase;
    end
    check("held_changes", 16'(changes), 16'd1);
    check("held_phase", 16'(game_phase), 16'(PH_TITLE));
    check("held_score_kept", 16'(p2_score), 16'd3);
    @(negedge Clk) start = 1'b0;
    check("rr_width", 16'(rr_wide), 16'd0);

`ifdef ROUND_TIMER_TIME_LIMIT_EN
    // Time limit with ROUND_FRAMES=120 and no hits
    press_start();
    send_ticks(90);
    check("tmr_phase", 16'(game_phase), 16'(PH_FIGHT));
    check("tmr_sec2", 16'(round_time_left), 16'd2);
    send_ticks(1);
    check("tmr_sec1a", 16'(round_time_left), 16'd1);
    send_ticks(59);
    check("tmr_sec1b", 16'(round_time_left), 16'd1);
    send_ticks(1);
    check("tmr_sec0", 16'(round_time_left), 16'd0);
    check("tmr_still_fight", 16'(game_phase), 16'(PH_FIGHT));
    send_ticks(58);
    check("tmr119_phase", 16'(game_phase), 16'(PH_FIGHT));
    send_ticks(1);
    check("tmr_timeout_phase", 16'(game_phase), 16'(PH_FREEZE));
    check("tmr_timeout_winner", 16'(winner), 16'd3);
    check("tmr_timeout_p1", 16'(p1_score), 16'd0);
    check("tmr_timeout_p2", 16'(p2_score), 16'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
